// File: rtl/sonar_event_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sonar_event_arbiter
// Brief    : Round-robin capture of sonar comparator rises into a timestamped
//            event FIFO, drained by the CPU over the per-slave Wishbone bus.
// Revision : 1.0 - initial release
// ============================================================================
module sonar_event_arbiter #(
    parameter int N_CH       = 15,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            ce_pcm,
    input  logic            mclear,
    input  logic [N_CH-1:0] cmp,
    input  logic            wb_valid_i,
    input  logic [3:0]      wbs_adr_i,
    input  logic [15:0]     wbs_dat_i,
    input  logic            wbs_strb_i,
    output logic            wbs_ack_o,
    output logic [15:0]     wbs_dat_o,
    output logic            irq_o
);

    localparam int             c_AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
    localparam logic [TS_W-1:0] c_TS_ONE  = TS_W'(1);

    localparam logic [3:0] c_ADR_CTRL   = 4'd0;
    localparam logic [3:0] c_ADR_MASK   = 4'd1;
    localparam logic [3:0] c_ADR_STATUS = 4'd2;
    localparam logic [3:0] c_ADR_EVT_CH = 4'd3;
    localparam logic [3:0] c_ADR_EVT_TS = 4'd4;
    localparam logic [3:0] c_ADR_TS_NOW = 4'd5;

    logic            r_en;
    logic [N_CH-1:0] r_mask;
    logic [N_CH-1:0] r_cmp_q;
    logic [N_CH-1:0] r_pend;
    logic            r_lost;
    logic [TS_W-1:0] r_ts;
    logic [3:0]      r_rr;
    logic [4:0]      r_count;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [3:0]      r_mem_ch [FIFO_DEPTH];
    logic [TS_W-1:0] r_mem_ts [FIFO_DEPTH];

    logic            w_acc;
    logic            w_wr;
    logic            w_rd;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_ts_clr;
    logic            w_lost_clr;
    logic            w_lost_set;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_clr_oh;
    logic [N_CH-1:0] w_pend_nxt;
    logic            w_gnt_vld;
    logic [3:0]      w_gnt_idx;
    logic [4:0]      w_idx;
    logic [3:0]      w_head_ch;
    logic [TS_W-1:0] w_head_ts;
    logic [15:0]     w_rdata;
    logic            w_unused;

    assign w_unused   = &{1'b0, wbs_dat_i};

    // An access is accepted only on the cycle ack is about to rise, so a held
    // valid produces one transfer every other cycle.
    assign w_acc      = wb_valid_i & ~wbs_ack_o;
    assign w_wr       = w_acc & wbs_strb_i;
    assign w_rd       = w_acc & ~wbs_strb_i;

    assign w_empty    = (r_count == 5'd0);
    assign w_full     = (r_count == 5'(FIFO_DEPTH));
    assign w_pop      = w_rd & (wbs_adr_i == c_ADR_EVT_TS) & ~w_empty;
    assign w_ts_clr   = w_wr & (wbs_adr_i == c_ADR_CTRL) & wbs_dat_i[1];
    assign w_lost_clr = w_wr & (wbs_adr_i == c_ADR_STATUS) & wbs_dat_i[10];

    assign w_rise     = cmp & ~r_cmp_q & r_mask & {N_CH{r_en}};
    assign w_push     = w_gnt_vld & ~w_full;

    assign w_head_ch  = r_mem_ch[r_rd_ptr];
    assign w_head_ts  = r_mem_ts[r_rd_ptr];

    // Walk downward so the nearest pending channel after r_rr is assigned last.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = 4'd0;
        w_idx     = 5'd0;
        for (int k = N_CH; k >= 1; k--) begin
            w_idx = {1'b0, r_rr} + 5'(k);
            if (w_idx >= 5'(N_CH)) begin
                w_idx = w_idx - 5'(N_CH);
            end
            if (r_pend[w_idx[3:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx[3:0];
            end
        end
    end

    always_comb begin
        w_clr_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_clr_oh[i] = w_push & (w_gnt_idx == 4'(i));
        end
    end

    // A rise coinciding with its own grant re-arms pend rather than counting as lost.
    assign w_pend_nxt = (r_pend & ~w_clr_oh) | w_rise;
    assign w_lost_set = |(w_rise & r_pend & ~w_clr_oh);

    always_comb begin
        w_rdata = 16'd0;
        case (wbs_adr_i)
            c_ADR_CTRL:   w_rdata = {15'd0, r_en};
            c_ADR_MASK:   w_rdata = 16'(r_mask);
            c_ADR_STATUS: w_rdata = {5'd0, r_lost, w_full, w_empty, 3'd0, r_count};
            c_ADR_EVT_CH: w_rdata = {~w_empty, 11'd0, w_head_ch};
            c_ADR_EVT_TS: w_rdata = w_empty ? 16'd0 : 16'(w_head_ts);
            c_ADR_TS_NOW: w_rdata = 16'(r_ts);
            default:      w_rdata = 16'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_en     <= 1'b0;
            r_mask   <= '1;
            r_cmp_q  <= '0;
            r_pend   <= '0;
            r_lost   <= 1'b0;
            r_ts     <= '0;
            r_rr     <= 4'(N_CH - 1);
            r_count  <= 5'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_cmp_q <= cmp;
            if (w_wr && (wbs_adr_i == c_ADR_CTRL)) begin
                r_en <= wbs_dat_i[0];
            end
            if (w_wr && (wbs_adr_i == c_ADR_MASK)) begin
                r_mask <= wbs_dat_i[N_CH-1:0];
            end
            if (w_push && !mclear) begin
                r_rr <= w_gnt_idx;
            end
            if (mclear) begin
                r_pend   <= '0;
                r_lost   <= 1'b0;
                r_ts     <= '0;
                r_count  <= 5'd0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                r_pend <= w_pend_nxt;
                if (w_lost_set) begin
                    r_lost <= 1'b1;
                end else if (w_lost_clr) begin
                    r_lost <= 1'b0;
                end
                if (w_ts_clr) begin
                    r_ts <= '0;
                end else if (ce_pcm) begin
                    r_ts <= r_ts + c_TS_ONE;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 5'd1;
                    2'b01:   r_count <= r_count - 5'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem_ch[r_wr_ptr] <= w_gnt_idx;
            r_mem_ts[r_wr_ptr] <= r_ts;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 16'd0;
            irq_o     <= 1'b0;
        end else begin
            wbs_ack_o <= w_acc;
            if (w_acc) begin
                wbs_dat_o <= w_rdata;
            end
            irq_o <= r_en & ~w_empty;
        end
    end

endmodule
`default_nettype wire
